align_grs_seq: RTL
==================

Name: align_grs_seq

Overview:
- Multi-cycle sequencer for the FPU adder's alignment step: right-shifts the smaller operand's mantissa by the exponent difference and produces the aligned mantissa plus guard, round and sticky bits for the rounder.
- Replaces a single-cycle 27-bit barrel shifter with one shift stage per cycle (16, 8, 4, 2, 1) and a registered working word.
- Sits between the exponent-compare stage and the significand add/round stage, with valid/ready handshakes on both sides.

Parameters:
- MANT_W, 24, mantissa width including hidden bit
- SHAMT_W, 8, exponent-difference width
- STAGES, 5, shift stages; stage k shifts by 2^k, with k = STAGES-1 down to 0

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort; returns to IDLE and discards any operation
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept; high only in IDLE
- mant_in  in  MANT_W  unaligned mantissa
- shamt  in  SHAMT_W  right-shift amount (exponent difference)
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  downstream accepts
- mant_out  out  MANT_W  aligned mantissa
- g, r, s  out  1 each  guard, round, sticky
- busy  out  1  high in SHIFT or DONE

Behaviour:
- Working word W is MANT_W+3 bits: {mantissa, g, r, s}. Outputs are driven directly from W: mant_out = W[MANT_W+2:3], g = W[2], r = W[1], s = W[0].
- Reset (async, rst_n low):
  - state goes to IDLE; W, the stage counter and the latched shamt all clear to 0.
  - out_valid = 0, in_ready = 1, busy = 0.
- States: IDLE, SHIFT, DONE.
- IDLE: on the edge where in_valid and in_ready are both high, load W = {mant_in, 3'b000} and latch shamt, then:
  - shamt == 0: go to DONE; W unchanged, so g = r = s = 0. Latency 1 cycle.
  - shamt >= MANT_W+2 (26): go to DONE with W = {0, 0, 0, |mant_in}. Latency 1 cycle.
  - otherwise: go to SHIFT with stage = STAGES-1.
- SHIFT: one stage per cycle.
  - If shamt[stage] = 1: W <= W >> 2^stage, and the new W[0] = old W[0] OR (OR of the 2^stage bits shifted out).
  - If shamt[stage] = 0: W is held.
  - stage decrements each cycle. After stage 0 is processed, go to DONE.
  - Fixed latency: 1 + STAGES = 6 cycles from acceptance to out_valid, regardless of shamt value.
- DONE: out_valid = 1 and all outputs stable.
  - On out_ready = 1, go to IDLE; out_valid drops the next cycle.
  - out_ready low holds every output unchanged for any number of cycles.
- in_ready = (state == IDLE). No new operand is accepted in the same cycle DONE hands off; throughput is 1 operation per 7+ cycles on the shift path.
- flush: synchronous, highest priority in every state. Next state is IDLE, out_valid = 0, W is cleared. A simultaneous in_valid is not accepted.
- Reset asserted mid-SHIFT: operation lost; outputs take reset values immediately, without waiting for a clock edge.
- Shift bits of shamt above STAGES-1 only matter through the >= 26 fast-path check. No wrap-around: for example, shamt = 32 takes the sticky fast path.
- Sticky is monotone: once W[0] = 1 it stays 1 until reload, flush or reset.

Decomposition:
- Shared FPU package holds:
  - MANT_W and the GRS width constant (3).
  - The state enum (IDLE, SHIFT, DONE).
  - A sticky-threshold constant, MANT_W+2.
- One sub-module: align_stage_shr, combinational. It takes W, a stage index and an enable bit and returns the shifted word with the sticky fold-in.
- The sequencer owns the FSM, the counter and the registers.

Test Plan:
- mant_in=0x800001, shamt=1 -> after 6 cycles: mant_out=0x400000, g=1, r=0, s=0.
- mant_in=0x800007, shamt=3 -> mant_out=0x100000, g=1, r=1, s=1; latency 6.
- mant_in=0xFFFFFF, shamt=16 -> mant_out=0x0000FF, g=r=s=1; hold out_ready low for 3 cycles and check the outputs stay stable and in_ready stays 0.
- mant_in=0x800000 with shamt=30, then with shamt=0:
  - shamt=30 -> out_valid after 1 cycle, mant_out=0, g=r=0, s=1.
  - shamt=0 -> out_valid after 1 cycle, mant_out=0x800000, g=r=s=0.
- Accept shamt=5, then pulse flush in the 3rd SHIFT cycle with in_valid=1 -> IDLE next cycle, out_valid never rises, the new operand is not taken.
- Accept shamt=9, then drop rst_n mid-SHIFT between clock edges -> out_valid=0, busy=0, in_ready=1 immediately. After release, a fresh operation gives correct results.

Source files
------------

// File: rtl/align_grs_seq_pkg.sv
// Shared constants and types for the FPU alignment sequencer.
// Holds the mantissa and GRS widths, the sticky fast-path threshold and the FSM state type.
package align_grs_seq_pkg;

  localparam int MANT_W  = 24;
  localparam int GRS_W   = 3;
  localparam int SHAMT_W = 8;
  localparam int STAGES  = 5;

  // A right shift of MANT_W+2 or more leaves only sticky information behind.
  function automatic int sticky_thresh(input int mant_w);
    return mant_w + 2;
  endfunction

  localparam int STICKY_THRESH = sticky_thresh(MANT_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/align_grs_seq_if.sv
// Handshake bus between exponent compare, the alignment sequencer and the add/round stage.
// The slave modport is the sequencer's view; master is the surrounding pipeline's view.
interface align_grs_seq_if #(
  parameter int MANT_W  = align_grs_seq_pkg::MANT_W,
  parameter int SHAMT_W = align_grs_seq_pkg::SHAMT_W
);

  logic               in_valid;
  logic               in_ready;
  logic [MANT_W-1:0]  mant_in;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [MANT_W-1:0]  mant_out;
  logic               g;
  logic               r;
  logic               s;

  modport slave (
    input  in_valid, mant_in, shamt, out_ready,
    output in_ready, out_valid, mant_out, g, r, s
  );

  modport master (
    output in_valid, mant_in, shamt, out_ready,
    input  in_ready, out_valid, mant_out, g, r, s
  );

endinterface

// File: rtl/align_grs_seq_stage_shr.sv
// One alignment stage: right-shift the working word by 2^stage when enabled,
// folding every bit that leaves or lands in the sticky position into W[0].
module align_stage_shr #(
  parameter int WORD_W  = 27,
  parameter int STAGE_W = 3
) (
  input  logic [WORD_W-1:0]  word_i,
  input  logic [STAGE_W-1:0] stage_i,
  input  logic               en_i,
  output logic [WORD_W-1:0]  word_o
);

  logic [WORD_W-1:0] shifted;
  logic              lost;

  // NOTE: every signal assigned here gets an unconditional value first, so no latch can be inferred.
  always_comb begin
    shifted = word_i >> (32'd1 << stage_i);
    lost    = |(word_i & ((WORD_W'(1) << (32'd1 << stage_i)) - WORD_W'(1)));
    word_o  = word_i;
    if (en_i) begin
      word_o = {shifted[WORD_W-1:1], shifted[0] | lost};
    end
  end

endmodule

// File: rtl/align_grs_seq.sv
// Multi-cycle alignment sequencer: shifts the smaller mantissa right one power-of-two
// stage per cycle and presents {mantissa, guard, round, sticky} to the rounder.
module align_grs_seq
  import align_grs_seq_pkg::*;
#(
  parameter int MANT_W  = align_grs_seq_pkg::MANT_W,
  parameter int SHAMT_W = align_grs_seq_pkg::SHAMT_W,
  parameter int STAGES  = align_grs_seq_pkg::STAGES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  output logic               busy,
  align_grs_seq_if.slave     bus
);

  localparam int W_W     = MANT_W + GRS_W;
  localparam int STG_W   = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int THRESH  = sticky_thresh(MANT_W);

  state_e             state_q;
  logic [W_W-1:0]     w_q;
  logic [W_W-1:0]     w_d;
  logic [STG_W-1:0]   stage_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic               out_valid_q;
  logic               in_ready_q;
  logic               busy_q;

  align_stage_shr #(
    .WORD_W  (W_W),
    .STAGE_W (STG_W)
  ) u_stage (
    .word_i  (w_q),
    .stage_i (stage_q),
    .en_i    (shamt_q[stage_q]),
    .word_o  (w_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w_q         <= '0;
      stage_q     <= '0;
      shamt_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      w_q         <= '0;
      stage_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            shamt_q    <= bus.shamt;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (bus.shamt == '0) begin
              w_q         <= {bus.mant_in, {GRS_W{1'b0}}};
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else if (bus.shamt >= SHAMT_W'(THRESH)) begin
              // Everything is shifted past the round bit; only the sticky survives.
              w_q         <= W_W'(|bus.mant_in);
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              w_q     <= {bus.mant_in, {GRS_W{1'b0}}};
              stage_q <= STG_W'(STAGES - 1);
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          w_q <= w_d;
          if (stage_q == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            stage_q <= stage_q - STG_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.mant_out  = w_q[W_W-1:GRS_W];
  assign bus.g         = w_q[2];
  assign bus.r         = w_q[1];
  assign bus.s         = w_q[0];
  assign busy          = busy_q;

endmodule
